rs_write_arbiter: RTL and testbench

Shares one combinational rs_write_decodifier (12-bit in, 12-bit out) between N_REQ requesters.
- Round-robin arbitration picks one requester; its codeword is captured and decoded.
- The result is registered and offered downstream on a valid/ready port, tagged with the requester id.
- Sits between the pad-level input muxing and the rs_write_decodifier instance in the top-level wrapper.

---
 rtl/rs_write_pkg.sv | 17 +
 rtl/rs_rr_arbiter.sv | 33 +++
 rtl/rs_write_decodifier.sv | 12 +
 rtl/rs_write_arbiter.sv | 123 ++++++++++++
 tb/tb_rs_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_write_pkg.sv
// Shared constants and types for the round-robin front end of the write-path decoder.
package rs_write_pkg;

  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // A single requester still needs a 1-bit id field, hence the floor of 1.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rs_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  win_id,
  output logic             any_req
);

  always_comb begin
    int idx;
    win_id = '0;
    idx    = 0;
    // Walk from farthest to nearest so the nearest asserted request wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        win_id = ID_W'(idx);
      end
    end
  end

  assign any_req = |req;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant[gi] = any_req && (win_id == ID_W'(gi));
  end

endmodule

// File: rtl/rs_write_decodifier.sv
// Combinational codeword remap shared by all write requesters.
module rs_write_decodifier (
  input  logic [11:0] code_in,
  output logic [11:0] data_out
);

  // Low nibble moves to the top; the rest are neighbour-differenced.
  assign data_out = {code_in[3:0],
                     code_in[7:4]  ^ code_in[3:0],
                     code_in[11:8] ^ code_in[7:4]};

endmodule

// File: rtl/rs_write_arbiter.sv
// Time-shares one rs_write_decodifier between N_REQ requesters; the result is
// registered and offered on a valid/ready port tagged with the requester id.
module rs_write_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = rs_write_pkg::DATA_W,
  parameter int ID_W   = rs_write_pkg::id_width(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic [7:0]                done_count
);

  import rs_write_pkg::*;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   cap_id_q, cap_id_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        done_count_q, done_count_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   win_id;
  logic              any_req;
  logic [DATA_W-1:0] dec_out;
  logic [DATA_W-1:0] req_word [N_REQ];

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rs_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .win_id  (win_id),
    .any_req (any_req)
  );

  rs_write_decodifier u_dec (
    .code_in  (cap_data_q),
    .data_out (dec_out)
  );

  // Grants are only offered while idle and never while reset is held.
  assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cap_id_d     = cap_id_q;
    cap_data_d   = cap_data_q;
    out_id_d     = out_id_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    done_count_d = done_count_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          cap_data_d = req_word[win_id];
          cap_id_d   = win_id;
          ptr_d      = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);
          state_d    = DECODE;
        end
      end
      DECODE: begin
        out_data_d  = dec_out;
        out_id_d    = cap_id_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          done_count_d = done_count_q + 8'd1;
          out_valid_d  = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cap_id_q     <= '0;
      cap_data_q   <= '0;
      out_id_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cap_id_q     <= cap_id_d;
      cap_data_q   <= cap_data_d;
      out_id_q     <= out_id_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      done_count_q <= done_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_rs_write_arbiter.sv
// Self-checking bench for rs_write_arbiter with two requesters: vector table,
// hand sequences for multi-cycle corners, and an output-handshake scoreboard.
module tb_rs_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [23:0] req_data;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_id;
  logic [7:0]  done_count;

  rs_write_arbiter #(.N_REQ(2), .DATA_W(12), .ID_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] data;
    logic        id;
  } exp_t;

  typedef struct {
    logic [1:0]  v;
    logic [11:0] d0;
    logic [11:0] d1;
    logic [1:0]  rdy;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_done = 0;
  logic tb_ptr = 1'b0;

  function automatic logic [11:0] gold(input logic [11:0] c);
    logic [3:0] n [3];
    n[0] = c[3:0];
    n[1] = c[7:4];
    n[2] = c[11:8];
    return {n[0], n[1] ^ n[0], n[2] ^ n[1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    exp_q.delete();
    exp_done = 0;
    tb_ptr = 1'b0;
    rst_n = 1'b1;
  endtask

  // One full transaction with out_ready high; exp_rdy is the expected grant.
  task automatic xact(input logic [1:0] v, input logic [11:0] d0, input logic [11:0] d1,
                      input logic [1:0] exp_rdy, input string tag);
    logic id;
    req_valid = v;
    req_data  = {d1, d0};
    out_ready = 1'b1;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      id = exp_rdy[1];
      exp_q.push_back('{data: gold(id ? d1 : d0), id: id});
      tb_ptr = ~id;
      step();
      chk({tag, ".dec_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".dec_valid"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      step();
    end else begin
      step();
    end
  endtask

  // Scoreboard: every completed output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      chk("hs.done_count", 32'(done_count), 32'(exp_done[7:0]));
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hs.unexpected: got data %0h id %0h expected no output", out_data, out_id);
      end else begin
        e = exp_q.pop_front();
        chk("hs.out_data", 32'(out_data), 32'(e.data));
        chk("hs.out_id", 32'(out_id), 32'(e.id));
      end
      exp_done++;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    logic [1:0]  rv;
    logic [11:0] r0, r1;
    logic [1:0]  er;

    vecs[0] = '{v: 2'b11, d0: 12'h123, d1: 12'h456, rdy: 2'b01};
    vecs[1] = '{v: 2'b11, d0: 12'h789, d1: 12'hABC, rdy: 2'b10};
    vecs[2] = '{v: 2'b11, d0: 12'hDEF, d1: 12'h0F1, rdy: 2'b01};
    vecs[3] = '{v: 2'b11, d0: 12'h2E3, d1: 12'hC4D, rdy: 2'b10};
    vecs[4] = '{v: 2'b01, d0: 12'hA5C, d1: 12'h000, rdy: 2'b01};
    vecs[5] = '{v: 2'b00, d0: 12'hFFF, d1: 12'hFFF, rdy: 2'b00};
    vecs[6] = '{v: 2'b01, d0: 12'h800, d1: 12'h001, rdy: 2'b01};
    vecs[7] = '{v: 2'b10, d0: 12'h555, d1: 12'hAAA, rdy: 2'b10};
    vecs[8] = '{v: 2'b10, d0: 12'h0F0, d1: 12'hF0F, rdy: 2'b10};
    vecs[9] = '{v: 2'b11, d0: 12'hFFF, d1: 12'h000, rdy: 2'b01};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_data  = 24'h0;
    out_ready = 1'b0;
    step();
    step();
    chk("reset.req_ready", 32'(req_ready), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data", 32'(out_data), 32'd0);
    chk("reset.out_id", 32'(out_id), 32'd0);
    chk("reset.done_count", 32'(done_count), 32'd0);
    exp_q.delete();
    exp_done = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      xact(vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].rdy, $sformatf("vec%0d", i));
    end
    chk("table.done_count", 32'(done_count), 32'd9);

    // Request 1 pulses only during DECODE and must never be granted.
    req_valid = 2'b01;
    req_data  = {12'h321, 12'h654};
    #1;
    chk("wd.ready", 32'(req_ready), 32'b01);
    exp_q.push_back('{data: gold(12'h654), id: 1'b0});
    step();
    req_valid = 2'b10;
    #1;
    chk("wd.dec_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 2'b00;
    step();
    chk("wd.idle_ready", 32'(req_ready), 32'd0);
    step();
    chk("wd.no_extra_valid", 32'(out_valid), 32'd0);
    chk("wd.done_count", 32'(done_count), 32'd10);
    xact(2'b11, 12'h9A9, 12'h3B3, 2'b10, "wd.after");

    // Backpressure: result held for five cycles while requester 1 waits.
    do_reset();
    out_ready = 1'b0;
    req_valid = 2'b01;
    req_data  = {12'h0F0, 12'h3C7};
    #1;
    chk("bp.ready", 32'(req_ready), 32'b01);
    exp_q.push_back('{data: gold(12'h3C7), id: 1'b0});
    step();
    req_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.hold%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp.hold%0d.data", i), 32'(out_data), 32'(gold(12'h3C7)));
      chk($sformatf("bp.hold%0d.id", i), 32'(out_id), 32'd0);
      chk($sformatf("bp.hold%0d.ready", i), 32'(req_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp.regrant", 32'(req_ready), 32'b10);
    exp_q.push_back('{data: gold(12'h0F0), id: 1'b1});
    step();
    req_valid = 2'b00;
    step();
    step();
    chk("bp.done_count", 32'(done_count), 32'd2);

    // Reset during DECODE.
    xact(2'b01, 12'h111, 12'h222, 2'b01, "rst.pre");
    req_valid = 2'b01;
    #1;
    chk("rst.abort_grant", 32'(req_ready), 32'b01);
    step();
    rst_n = 1'b0;
    req_valid = 2'b11;
    step();
    chk("rst.dec.out_valid", 32'(out_valid), 32'd0);
    chk("rst.dec.out_data", 32'(out_data), 32'd0);
    chk("rst.dec.done_count", 32'(done_count), 32'd0);
    chk("rst.dec.req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    exp_done = 0;
    tb_ptr = 1'b0;
    rst_n = 1'b1;
    xact(2'b11, 12'h7E1, 12'h1E7, 2'b01, "rst.dec.after");

    // Reset during HOLD.
    req_valid = 2'b11;
    req_data  = {12'hB0B, 12'hCAB};
    #1;
    chk("rst.hold.grant", 32'(req_ready), 32'b10);
    step();
    out_ready = 1'b0;
    step();
    chk("rst.hold.valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst.hold.out_valid", 32'(out_valid), 32'd0);
    chk("rst.hold.out_data", 32'(out_data), 32'd0);
    chk("rst.hold.out_id", 32'(out_id), 32'd0);
    chk("rst.hold.done_count", 32'(done_count), 32'd0);
    exp_q.delete();
    exp_done = 0;
    tb_ptr = 1'b0;
    rst_n = 1'b1;
    xact(2'b11, 12'h4D2, 12'h2D4, 2'b01, "rst.hold.after");

    // 256 back-to-back random transactions wrap done_count to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      rv = 2'($urandom_range(1, 3));
      r0 = 12'($urandom);
      r1 = 12'($urandom);
      er = rv[tb_ptr] ? (2'b01 << tb_ptr) : (2'b01 << ~tb_ptr);
      xact(rv, r0, r1, er, $sformatf("wrap%0d", i));
    end
    req_valid = 2'b00;
    step();
    chk("wrap.done_count", 32'(done_count), 32'd0);
    chk("wrap.out_valid", 32'(out_valid), 32'd0);
    chk("end.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
